// File: rtl/rrat_freelist_if.sv
// ---------------------------------------------------------------------------
// rrat_freelist_if
//   Bundles the rename/commit-side signals of the retirement RAT and free
//   list into one interface.
//
//   master : driven by the rename stage / ROB (requests, commits, flush)
//   slave  : the rrat_freelist block (free-list head, RRAT, occupancy)
//
//   Signals
//     alloc_req     rename consumes one free preg this cycle
//     alloc_pd      preg at the speculative head
//     alloc_ok      free list non-empty; alloc_req accepted only when high
//     commit_valid  ROB retires one instruction this cycle
//     commit_rd     logical destination of the retiring instruction
//     commit_pd     preg that instruction was renamed to
//     flush_valid   mispredict / exception recovery
//     rrat_map      architectural mapping, one preg per logical register
//     free_count    speculative free entries
// ---------------------------------------------------------------------------
interface rrat_freelist_if #(
  parameter int LOG_REGS = 32,
  parameter int PHY_REGS = 64
);
  localparam int LOG_BITS = $clog2(LOG_REGS);
  localparam int PRF_BITS = $clog2(PHY_REGS);
  localparam int FL_DEPTH = PHY_REGS - LOG_REGS;
  localparam int PTR_BITS = $clog2(FL_DEPTH) + 1;

  logic                               alloc_req;
  logic [PRF_BITS-1:0]                alloc_pd;
  logic                               alloc_ok;
  logic                               commit_valid;
  logic [LOG_BITS-1:0]                commit_rd;
  logic [PRF_BITS-1:0]                commit_pd;
  logic                               flush_valid;
  logic [LOG_REGS-1:0][PRF_BITS-1:0]  rrat_map;
  logic [PTR_BITS-1:0]                free_count;

  modport master (
    output alloc_req, commit_valid, commit_rd, commit_pd, flush_valid,
    input  alloc_pd, alloc_ok, rrat_map, free_count
  );

  modport slave (
    input  alloc_req, commit_valid, commit_rd, commit_pd, flush_valid,
    output alloc_pd, alloc_ok, rrat_map, free_count
  );
endinterface

// File: rtl/rrat_freelist.sv
// ---------------------------------------------------------------------------
// rrat_freelist
//   Commit-side counterpart of the speculative rename table. Holds the
//   retirement RAT (driven back to rename on flush) and owns the physical
//   register free list. Two heads are kept: the speculative head advances on
//   rename allocation, the architectural head on commit. A flush copies the
//   architectural head into the speculative head, restoring the list in one
//   cycle. Committing a destination pushes its previous mapping at the tail.
//
//   Ports
//     clk   clock
//     rst   synchronous, active-high reset
//     bus   rrat_freelist_if.slave (alloc / commit / flush / rrat_map /
//           free_count)
//
//   Parameters
//     LOG_REGS  logical registers (core NUM_ARCH_REG, 32)
//     PHY_REGS  physical registers (core NUM_PHYS_REG, 64); > LOG_REGS and
//               PHY_REGS - LOG_REGS must be a power of two
//
//   Build option
//     RRAT_FREELIST_BYPASS_EN : when the speculative list is empty, forward
//     the preg being pushed by a same-cycle commit straight to alloc_pd.
// ---------------------------------------------------------------------------
module rrat_freelist #(
  parameter int LOG_REGS = 32,
  parameter int PHY_REGS = 64
) (
  input  logic           clk,
  input  logic           rst,
  rrat_freelist_if.slave bus
);
  localparam int LOG_BITS = $clog2(LOG_REGS);
  localparam int PRF_BITS = $clog2(PHY_REGS);
  localparam int FL_DEPTH = PHY_REGS - LOG_REGS;
  localparam int IDX_BITS = $clog2(FL_DEPTH);
  localparam int PTR_BITS = IDX_BITS + 1;

  typedef logic [PRF_BITS-1:0] preg_t;
  typedef logic [PTR_BITS-1:0] ptr_t;
  typedef logic [IDX_BITS-1:0] idx_t;

  generate
    if (PHY_REGS <= LOG_REGS) begin : g_bad_regs
      $error("rrat_freelist: PHY_REGS must exceed LOG_REGS");
    end
    if ((FL_DEPTH & (FL_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rrat_freelist: PHY_REGS - LOG_REGS must be a power of two");
    end
  endgenerate

  preg_t r_fl   [FL_DEPTH];
  preg_t r_rrat [LOG_REGS];
  ptr_t  r_tail;
  ptr_t  r_spec_head;
  ptr_t  r_arch_head;

  logic  w_commit;
  logic  w_empty;
  logic  w_bypass;
  logic  w_alloc_ok;
  logic  w_alloc_fire;
  preg_t w_old_pd;
  preg_t w_alloc_pd;
  idx_t  w_spec_idx;
  idx_t  w_tail_idx;
  ptr_t  w_tail_next;
  ptr_t  w_arch_next;

  // Writes to x0 are not renamed, so they neither reclaim nor retire a preg.
  assign w_commit    = bus.commit_valid && (bus.commit_rd != '0);
  assign w_old_pd    = r_rrat[bus.commit_rd];
  assign w_spec_idx  = r_spec_head[IDX_BITS-1:0];
  assign w_tail_idx  = r_tail[IDX_BITS-1:0];
  // Equal pointers including the wrap bit means empty; a full list differs
  // only in the wrap bit.
  assign w_empty     = (r_spec_head == r_tail);
  assign w_tail_next = r_tail + ptr_t'(w_commit);
  assign w_arch_next = r_arch_head + ptr_t'(w_commit);

`ifdef RRAT_FREELIST_BYPASS_EN
  // Empty list: hand out the old mapping being freed this very cycle. The
  // slot written at the tail is the one the speculative head points at, so
  // advancing both pointers consumes it immediately.
  assign w_bypass = w_empty && w_commit;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_alloc_ok   = !w_empty || w_bypass;
  assign w_alloc_pd   = w_bypass ? w_old_pd : r_fl[w_spec_idx];
  assign w_alloc_fire = bus.alloc_req && w_alloc_ok && !bus.flush_valid;

  assign bus.alloc_ok   = w_alloc_ok;
  assign bus.alloc_pd   = w_alloc_pd;
  assign bus.free_count = r_tail - r_spec_head;

  always_comb begin
    for (int i = 0; i < LOG_REGS; i++) begin
      bus.rrat_map[i] = r_rrat[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both arrays are deliberately reset: the free list must start
      // full of the non-architectural pregs and the RRAT must be the
      // identity, so neither can be left as uninitialised RAM.
      for (int k = 0; k < FL_DEPTH; k++) begin
        r_fl[k] <= preg_t'(LOG_REGS + k);
      end
      for (int i = 0; i < LOG_REGS; i++) begin
        r_rrat[i] <= preg_t'(i);
      end
      r_spec_head <= '0;
      r_arch_head <= '0;
      r_tail      <= ptr_t'(FL_DEPTH);
    end else begin
      if (w_commit) begin
        r_fl[w_tail_idx]       <= w_old_pd;
        r_rrat[bus.commit_rd]  <= bus.commit_pd;
      end
      r_tail      <= w_tail_next;
      r_arch_head <= w_arch_next;
      // A same-cycle commit is older than the flush, so the restored head
      // includes its increment.
      if (bus.flush_valid) begin
        r_spec_head <= w_arch_next;
      end else if (w_alloc_fire) begin
        r_spec_head <= r_spec_head + ptr_t'(1);
      end
    end
  end

`ifndef SYNTHESIS
  ap_commit_pd_nonzero : assert property (@(posedge clk) disable iff (rst)
    w_commit |-> (bus.commit_pd != '0))
    else $error("rrat_freelist: commit to rd!=0 with commit_pd==0");

  ap_occupancy_bound : assert property (@(posedge clk) disable iff (rst)
    ptr_t'(r_tail - r_arch_head) <= ptr_t'(FL_DEPTH))
    else $error("rrat_freelist: tail - arch_head exceeds FL_DEPTH");

  ap_arch_behind_spec : assert property (@(posedge clk) disable iff (rst)
    ptr_t'(r_spec_head - r_arch_head) <= ptr_t'(FL_DEPTH))
    else $error("rrat_freelist: arch_head passed spec_head");
`endif

endmodule
